// File: rtl/score_tracker.sv
// Pipe-pass score counter kept directly in BCD, with saturation, a high score that
// survives restarts, and seven-segment decode of both the score and the high score.

module score_display (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  // Active-low segments, bit order {g,f,e,d,c,b,a}; non-decimal codes blank.
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module score_pass_det #(
  parameter int X_WIDTH = 11
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [X_WIDTH-1:0] bird_x,
  input  logic [X_WIDTH-1:0] pipe_x,
  output logic               pass
);
  logic hit, prev;

  assign hit  = (bird_x == pipe_x);
  assign pass = hit & ~prev;

  // prev tracks equality every cycle, restart included, so a bird parked on a
  // pipe through a restart is not scored until it leaves and returns.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prev <= 1'b0;
    else        prev <= hit;
  end
endmodule

module score_tracker #(
  parameter int DIGITS    = 3,
  parameter int NUM_PIPES = 2,
  parameter int X_WIDTH   = 11
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           restart,
  input  logic                           collision,
  input  logic [X_WIDTH-1:0]             bird_x,
  input  logic [NUM_PIPES*X_WIDTH-1:0]   pipe_x,
  output logic [4*DIGITS-1:0]            score_bcd,
  output logic [4*DIGITS-1:0]            high_bcd,
  output logic                           new_high,
  output logic                           game_over,
  output logic                           score_pulse,
  output logic [14*DIGITS-1:0]           score_digits
);
  typedef enum logic {PLAY, OVER} state_t;

  state_t                 state;
  logic [NUM_PIPES-1:0]   pass;
  logic [3:0]             k;
  logic [3:0]             carry;
  logic [4:0]             dsum;
  logic [4*DIGITS-1:0]    sum_bcd;
  logic [4*DIGITS-1:0]    next_bcd;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
      score_pass_det #(.X_WIDTH(X_WIDTH)) u_det (
        .clock  (clock),
        .reset  (reset),
        .bird_x (bird_x),
        .pipe_x (pipe_x[gi*X_WIDTH +: X_WIDTH]),
        .pass   (pass[gi])
      );
    end
  endgenerate

  always_comb begin
    k = 4'd0;
    for (int i = 0; i < NUM_PIPES; i++) k = k + 4'(pass[i]);
  end

  // Ripple decimal add: k (<=9) enters the ones digit, later digits see a 0/1 carry.
  always_comb begin
    carry   = k;
    dsum    = 5'd0;
    sum_bcd = '0;
    for (int d = 0; d < DIGITS; d++) begin
      dsum = 5'(score_bcd[4*d +: 4]) + 5'(carry);
      if (dsum > 5'd9) begin
        sum_bcd[4*d +: 4] = 4'(dsum - 5'd10);
        carry             = 4'd1;
      end else begin
        sum_bcd[4*d +: 4] = dsum[3:0];
        carry             = 4'd0;
      end
    end
    next_bcd = (carry != 4'd0) ? {DIGITS{4'h9}} : sum_bcd;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= PLAY;
      score_bcd   <= '0;
      high_bcd    <= '0;
      new_high    <= 1'b0;
      score_pulse <= 1'b0;
    end else begin
      score_pulse <= 1'b0;
      if (restart) begin
        state     <= PLAY;
        score_bcd <= '0;
        new_high  <= 1'b0;
      end else if (state == PLAY) begin
        if (collision) begin
          state <= OVER;
          // Packed BCD orders the same as its decimal value.
          if (score_bcd > high_bcd) begin
            high_bcd <= score_bcd;
            new_high <= 1'b1;
          end
        end else if (next_bcd != score_bcd) begin
          score_bcd   <= next_bcd;
          score_pulse <= 1'b1;
        end
      end
    end
  end

  assign game_over = (state == OVER);

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_disp
      score_display u_score (
        .bcd (score_bcd[4*gi +: 4]),
        .seg (score_digits[7*gi +: 7])
      );
      score_display u_high (
        .bcd (high_bcd[4*gi +: 4]),
        .seg (score_digits[7*DIGITS + 7*gi +: 7])
      );
    end
  endgenerate
endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker against an integer-valued game model.

module tb_score_tracker;
  localparam int D  = 3;
  localparam int NP = 2;
  localparam int XW = 11;
  localparam int MAXV = 999;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              restart = 1'b0;
  logic              collision = 1'b0;
  logic [XW-1:0]     bird_x = '0;
  logic [NP*XW-1:0]  pipe_x = '0;
  logic [4*D-1:0]    score_bcd, high_bcd;
  logic              new_high, game_over, score_pulse;
  logic [14*D-1:0]   score_digits;

  score_tracker #(.DIGITS(D), .NUM_PIPES(NP), .X_WIDTH(XW)) dut (
    .clock        (clock),
    .reset        (reset),
    .restart      (restart),
    .collision    (collision),
    .bird_x       (bird_x),
    .pipe_x       (pipe_x),
    .score_bcd    (score_bcd),
    .high_bcd     (high_bcd),
    .new_high     (new_high),
    .game_over    (game_over),
    .score_pulse  (score_pulse),
    .score_digits (score_digits)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Behavioural model: decimal integers and a per-pipe "was on it" flag.
  int m_score, m_high;
  bit m_nh, m_over, m_pulse;
  bit m_on[NP];

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int d = 0; d < D; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int n);
    logic [6:0] t[10];
    t[0] = 7'b1000000; t[1] = 7'b1111001; t[2] = 7'b0100100; t[3] = 7'b0110000;
    t[4] = 7'b0011001; t[5] = 7'b0010010; t[6] = 7'b0000010; t[7] = 7'b1111000;
    t[8] = 7'b0000000; t[9] = 7'b0010000;
    return t[n];
  endfunction

  function automatic logic [14*D-1:0] exp_digits();
    logic [14*D-1:0] r;
    int p;
    p = 1;
    for (int d = 0; d < D; d++) begin
      r[7*d +: 7]       = seg_of((m_score / p) % 10);
      r[7*D + 7*d +: 7] = seg_of((m_high / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [8*D+2:0] exp_vec();
    return {to_bcd(m_score), to_bcd(m_high), m_nh, m_over, m_pulse};
  endfunction

  wire [8*D+2:0] dut_vec = {score_bcd, high_bcd, new_high, game_over, score_pulse};

  task automatic model_reset();
    m_score = 0; m_high = 0; m_nh = 0; m_over = 0; m_pulse = 0;
    for (int i = 0; i < NP; i++) m_on[i] = 0;
  endtask

  task automatic model_edge();
    int passes;
    bit on;
    passes = 0;
    for (int i = 0; i < NP; i++) begin
      on = (bird_x == pipe_x[i*XW +: XW]);
      if (on && !m_on[i]) passes++;
      m_on[i] = on;
    end
    m_pulse = 0;
    if (restart) begin
      m_over = 0; m_score = 0; m_nh = 0;
    end else if (!m_over) begin
      if (collision) begin
        m_over = 1;
        if (m_score > m_high) begin m_high = m_score; m_nh = 1; end
      end else begin
        int nv;
        nv = (m_score + passes > MAXV) ? MAXV : m_score + passes;
        m_pulse = (nv != m_score);
        m_score = nv;
      end
    end
  endtask

  // One clock: drive after the falling edge, advance model at the rising edge.
  task automatic cyc(input int b, input int p0, input int p1, input bit rs, input bit col);
    @(negedge clock);
    bird_x = XW'(b);
    pipe_x = {XW'(p1), XW'(p0)};
    restart = rs;
    collision = col;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic add_single(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 40, 500, 0, 0);
      cyc(40, 40, 500, 0, 0);
    end
  endtask

  task automatic add_double(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 40, 40, 0, 0);
      cyc(40, 40, 40, 0, 0);
    end
  endtask

  task automatic hard_reset();
    @(negedge clock);
    #2;
    reset = 1'b0;
    bird_x = XW'($urandom);
    pipe_x = {XW'($urandom), XW'($urandom)};
    restart = 1'($urandom);
    collision = 1'($urandom);
    model_reset();
    @(negedge clock);
    bird_x = '0; pipe_x = {XW'(500), XW'(40)}; restart = 0; collision = 0;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    int pulses;
    hard_reset();
    add_single(3);
    // Async reset mid-cycle: outputs must clear before any clock edge.
    @(negedge clock);
    #2;
    reset = 1'b0;
    bird_x = XW'($urandom); pipe_x = {XW'($urandom), XW'($urandom)};
    restart = 1'($urandom); collision = 1'($urandom);
    #1;
    model_reset();
    tests++;
    if (dut_vec !== exp_vec() || dut_vec !== '0) begin
      fails++; $display("FAIL reset_async got %h exp %h", dut_vec, exp_vec());
    end
    tests++;
    if (score_digits !== exp_digits()) begin
      fails++; $display("FAIL reset_digits got %h exp %h", score_digits, exp_digits());
    end
    @(negedge clock);
    bird_x = '0; pipe_x = {XW'(500), XW'(40)}; restart = 0; collision = 0;
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(40, 40, 500, 0, 0);
      if (score_pulse === 1'b1) pulses++;
      if (i == 0) begin
        tests++;
        if (score_bcd !== 12'h001 || score_pulse !== 1'b1) begin
          fails++; $display("FAIL reset_first_pass got %h/%b exp 001/1", score_bcd, score_pulse);
        end
      end
    end
    tests++;
    if (pulses != 1 || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL reset_hold pulses got %0d exp 1, vec got %h exp %h", pulses, dut_vec, exp_vec());
    end
  endtask

  task automatic test_simultaneous();
    hard_reset();
    add_single(9);
    tests++;
    if (score_bcd !== 12'h009) begin
      fails++; $display("FAIL simul_pre got %h exp 009", score_bcd);
    end
    cyc(0, 40, 40, 0, 0);
    cyc(40, 40, 40, 0, 0);
    tests++;
    if (score_bcd !== 12'h011 || score_pulse !== 1'b1 || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL simul_carry got %h/%b exp 011/1", score_bcd, score_pulse);
    end
    cyc(40, 40, 40, 0, 0);
    tests++;
    if (score_pulse !== 1'b0 || score_bcd !== 12'h011) begin
      fails++; $display("FAIL simul_once got %h/%b exp 011/0", score_bcd, score_pulse);
    end
  endtask

  task automatic test_saturation();
    hard_reset();
    add_double(499);
    tests++;
    if (score_bcd !== 12'h998 || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL sat_pre got %h exp 998", score_bcd);
    end
    cyc(0, 40, 40, 0, 0);
    cyc(40, 40, 40, 0, 0);
    tests++;
    if (score_bcd !== 12'h999 || score_pulse !== 1'b1) begin
      fails++; $display("FAIL sat_clip got %h/%b exp 999/1", score_bcd, score_pulse);
    end
    cyc(0, 40, 500, 0, 0);
    cyc(40, 40, 500, 0, 0);
    tests++;
    if (score_bcd !== 12'h999 || score_pulse !== 1'b0 || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL sat_hold got %h/%b exp 999/0", score_bcd, score_pulse);
    end
  endtask

  task automatic test_high_score();
    hard_reset();
    add_single(12);
    cyc(0, 40, 500, 0, 1);
    tests++;
    if (game_over !== 1'b1 || high_bcd !== 12'h012 || new_high !== 1'b1 || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL high_set got %h exp %h", dut_vec, exp_vec());
    end
    add_single(2);
    cyc(0, 40, 500, 0, 1);
    tests++;
    if (score_bcd !== 12'h012 || game_over !== 1'b1 || high_bcd !== 12'h012) begin
      fails++; $display("FAIL high_frozen got %h exp %h", dut_vec, exp_vec());
    end
    cyc(0, 40, 500, 1, 0);
    add_single(5);
    cyc(0, 40, 500, 0, 1);
    tests++;
    if (high_bcd !== 12'h012 || new_high !== 1'b0 || score_bcd !== 12'h005 || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL high_keep got %h exp %h", dut_vec, exp_vec());
    end
    tests++;
    if (score_digits !== exp_digits()) begin
      fails++; $display("FAIL high_digits got %h exp %h", score_digits, exp_digits());
    end
  endtask

  task automatic test_priority();
    hard_reset();
    add_single(7);
    cyc(0, 40, 500, 0, 0);
    cyc(40, 40, 500, 0, 1);
    tests++;
    if (score_bcd !== 12'h007 || high_bcd !== 12'h007 || game_over !== 1'b1 || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL prio_col_pass got %h exp %h", dut_vec, exp_vec());
    end
    cyc(0, 40, 500, 1, 1);
    tests++;
    if (game_over !== 1'b0 || score_bcd !== 12'h000 || high_bcd !== 12'h007 || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL prio_rst_col got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_restart_on_pipe();
    hard_reset();
    cyc(300, 100, 300, 0, 0);
    cyc(300, 100, 300, 0, 1);
    cyc(300, 100, 300, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(300, 100, 300, 0, 0);
      tests++;
      if (score_bcd !== 12'h000 || score_pulse !== 1'b0 || dut_vec !== exp_vec()) begin
        fails++; $display("FAIL onpipe_hold%0d got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    tests++;
    if (score_digits[7*D-1:0] !== {seg_of(0), seg_of(0), seg_of(0)}) begin
      fails++; $display("FAIL onpipe_digits got %h exp %h", score_digits[7*D-1:0], {seg_of(0), seg_of(0), seg_of(0)});
    end
    cyc(0, 100, 300, 0, 0);
    cyc(300, 100, 300, 0, 0);
    tests++;
    if (score_bcd !== 12'h001 || score_pulse !== 1'b1) begin
      fails++; $display("FAIL onpipe_rise got %h/%b exp 001/1", score_bcd, score_pulse);
    end
  endtask

  task automatic test_random();
    int p0, p1, b;
    int bad;
    hard_reset();
    p0 = 100; p1 = 200; bad = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) p0 = $urandom_range(0, 2047);
      if ($urandom_range(0, 7) == 0) p1 = $urandom_range(0, 2047);
      case ($urandom_range(0, 3))
        0: b = p0;
        1: b = p1;
        2: b = $urandom_range(0, 2047);
        default: b = int'(bird_x);
      endcase
      cyc(b, p0, p1, $urandom_range(0, 24) == 0, $urandom_range(0, 19) == 0);
      tests++;
      if (dut_vec !== exp_vec() || score_digits !== exp_digits()) begin
        fails++;
        if (bad < 5) $display("FAIL random_cyc%0d got %h exp %h", i, dut_vec, exp_vec());
        bad++;
      end
    end
  endtask

  initial begin
    model_reset();
    #17;
    reset = 1'b1;
    test_reset();
    test_simultaneous();
    test_saturation();
    test_high_score();
    test_priority();
    test_restart_on_pipe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
